// File: rtl/touch_pkg.sv
// Shared constants and FSM state type for the touch_filter slice.
package touch_pkg;
    localparam int unsigned RAW_W = 12;
    localparam int unsigned PIX_W = 9;

    localparam int unsigned DEF_AVG_LOG2    = 2;
    localparam int unsigned DEF_Z_THRESH    = 256;
    localparam int unsigned DEF_X_OFFSET    = 150;
    localparam int unsigned DEF_Y_OFFSET    = 300;
    localparam int unsigned DEF_SCALE_SHIFT = 2;
    localparam int unsigned DEF_RELEASE_CNT = 4;

    localparam int unsigned TFT_W     = 480;
    localparam int unsigned TFT_H     = 272;
    localparam int unsigned DEF_X_MAX = TFT_W - 1;
    localparam int unsigned DEF_Y_MAX = TFT_H - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_CALC
    } touch_state_e;
endpackage

// File: rtl/touch_filter_if.sv
// Sample input and latched-position output bundle between touchpad side and TFT side.
interface touch_filter_if;
    import touch_pkg::*;

    logic             sample_valid;
    logic [RAW_W-1:0] raw_x;
    logic [RAW_W-1:0] raw_y;
    logic [RAW_W-1:0] raw_z;
    logic             new_frame;
    logic [PIX_W-1:0] touch_x;
    logic [PIX_W-1:0] touch_y;
    logic             touch_valid;
    logic             touch_active;

    modport master (
        output sample_valid, raw_x, raw_y, raw_z, new_frame,
        input  touch_x, touch_y, touch_valid, touch_active
    );

    modport slave (
        input  sample_valid, raw_x, raw_y, raw_z, new_frame,
        output touch_x, touch_y, touch_valid, touch_active
    );
endinterface

// File: rtl/touch_calib.sv
// Combinational per-axis calibration: floor at offset, scale by right shift, clamp to panel edge.
module touch_calib
    import touch_pkg::*;
#(
    parameter int unsigned OFFSET = DEF_X_OFFSET,
    parameter int unsigned SHIFT  = DEF_SCALE_SHIFT,
    parameter int unsigned MAX    = DEF_X_MAX,
    parameter int unsigned IN_W   = RAW_W
) (
    input  logic [IN_W-1:0]  avg_i,
    output logic [PIX_W-1:0] pix_o
);
    localparam logic [IN_W-1:0] OFFSET_W = IN_W'(OFFSET);
    localparam logic [IN_W-1:0] MAX_W    = IN_W'(MAX);

    logic [IN_W-1:0] diff;
    logic [IN_W-1:0] scaled;
    logic [IN_W-1:0] clamped;

    always_comb begin
        diff    = (avg_i < OFFSET_W) ? '0 : avg_i - OFFSET_W;
        scaled  = diff >> SHIFT;
        clamped = (scaled > MAX_W) ? MAX_W : scaled;
        pix_o   = PIX_W'(clamped);
    end
endmodule

// File: rtl/touch_filter.sv
// Pressure-qualified averaging of touchpad samples, calibrated to pixels and latched on TFT frames.
module touch_filter
    import touch_pkg::*;
#(
    parameter int unsigned AVG_LOG2    = DEF_AVG_LOG2,
    parameter int unsigned Z_THRESH    = DEF_Z_THRESH,
    parameter int unsigned X_OFFSET    = DEF_X_OFFSET,
    parameter int unsigned Y_OFFSET    = DEF_Y_OFFSET,
    parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int unsigned X_MAX       = DEF_X_MAX,
    parameter int unsigned Y_MAX       = DEF_Y_MAX,
    parameter int unsigned RELEASE_CNT = DEF_RELEASE_CNT
) (
    input logic         cclk,
    input logic         rstb,
    touch_filter_if.slave bus
);
    localparam int unsigned SUM_W = RAW_W + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam int unsigned REL_W = $clog2(RELEASE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);
    localparam logic [REL_W-1:0] REL_MAX  = REL_W'(RELEASE_CNT);
    localparam logic [RAW_W-1:0] Z_MIN    = RAW_W'(Z_THRESH);

    touch_state_e     state_q, state_d;
    logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REL_W-1:0] rel_q, rel_d;
    logic             pend_q, pend_d;
    logic [PIX_W-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [PIX_W-1:0] touch_x_q, touch_x_d, touch_y_q, touch_y_d;
    logic             touch_valid_q, touch_valid_d;
    logic             touch_active_q, touch_active_d;

    logic             pressed;
    logic             release_hit;
    logic [PIX_W-1:0] calib_x, calib_y;

    touch_calib #(.OFFSET(X_OFFSET), .SHIFT(SCALE_SHIFT), .MAX(X_MAX), .IN_W(RAW_W)) u_calib_x (
        .avg_i(RAW_W'(sum_x_q >> AVG_LOG2)),
        .pix_o(calib_x)
    );

    touch_calib #(.OFFSET(Y_OFFSET), .SHIFT(SCALE_SHIFT), .MAX(Y_MAX), .IN_W(RAW_W)) u_calib_y (
        .avg_i(RAW_W'(sum_y_q >> AVG_LOG2)),
        .pix_o(calib_y)
    );

    assign pressed = bus.raw_z >= Z_MIN;

    always_comb begin
        state_d        = state_q;
        sum_x_d        = sum_x_q;
        sum_y_d        = sum_y_q;
        cnt_d          = cnt_q;
        rel_d          = rel_q;
        pend_d         = pend_q;
        pend_x_d       = pend_x_q;
        pend_y_d       = pend_y_q;
        touch_x_d      = touch_x_q;
        touch_y_d      = touch_y_q;
        touch_valid_d  = 1'b0;
        touch_active_d = touch_active_q;
        release_hit    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (bus.sample_valid) begin
                    if (pressed) begin
                        sum_x_d = sum_x_q + SUM_W'(bus.raw_x);
                        sum_y_d = sum_y_q + SUM_W'(bus.raw_y);
                        cnt_d   = cnt_q + 1'b1;
                        rel_d   = '0;
                        state_d = (cnt_d == CNT_FULL) ? ST_CALC : ST_ACCUM;
                    end else begin
                        sum_x_d     = '0;
                        sum_y_d     = '0;
                        cnt_d       = '0;
                        state_d     = ST_IDLE;
                        rel_d       = (rel_q == REL_MAX) ? rel_q : rel_q + 1'b1;
                        release_hit = (rel_d == REL_MAX);
                    end
                end
            end
            ST_CALC: begin
                pend_x_d = calib_x;
                pend_y_d = calib_y;
                pend_d   = 1'b1;
                sum_x_d  = '0;
                sum_y_d  = '0;
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Release overrides a same-edge frame latch; a result landing this edge stays pending.
        if (release_hit) begin
            touch_active_d = 1'b0;
            pend_d         = 1'b0;
        end else if (bus.new_frame && pend_q) begin
            touch_x_d      = pend_x_q;
            touch_y_d      = pend_y_q;
            touch_valid_d  = 1'b1;
            touch_active_d = 1'b1;
            if (state_q != ST_CALC) pend_d = 1'b0;
        end
    end

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            state_q        <= ST_IDLE;
            sum_x_q        <= '0;
            sum_y_q        <= '0;
            cnt_q          <= '0;
            rel_q          <= '0;
            pend_q         <= 1'b0;
            pend_x_q       <= '0;
            pend_y_q       <= '0;
            touch_x_q      <= '0;
            touch_y_q      <= '0;
            touch_valid_q  <= 1'b0;
            touch_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sum_x_q        <= sum_x_d;
            sum_y_q        <= sum_y_d;
            cnt_q          <= cnt_d;
            rel_q          <= rel_d;
            pend_q         <= pend_d;
            pend_x_q       <= pend_x_d;
            pend_y_q       <= pend_y_d;
            touch_x_q      <= touch_x_d;
            touch_y_q      <= touch_y_d;
            touch_valid_q  <= touch_valid_d;
            touch_active_q <= touch_active_d;
        end
    end

    assign bus.touch_x      = touch_x_q;
    assign bus.touch_y      = touch_y_q;
    assign bus.touch_valid  = touch_valid_q;
    assign bus.touch_active = touch_active_q;
endmodule

// File: tb/tb_touch_filter.sv
// Directed bench for touch_filter: averaging, calibration, frame latch, release and reset.
module tb_touch_filter;
    logic cclk;
    logic rstb;
    int   errors;
    int   checks;

    touch_filter_if bus ();

    touch_filter u_dut (
        .cclk(cclk),
        .rstb(rstb),
        .bus (bus)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    // Two idle edges, then one sample captured at the next edge; returns #1 after that edge.
    task automatic send_sample(input int x, input int y, input int z);
        repeat (2) @(posedge cclk);
        #1;
        bus.sample_valid = 1'b1;
        bus.raw_x = 12'(x);
        bus.raw_y = 12'(y);
        bus.raw_z = 12'(z);
        @(posedge cclk);
        #1;
        bus.sample_valid = 1'b0;
    endtask

    task automatic send_set(input int x, input int y);
        for (int unsigned i = 0; i < 4; i++) send_sample(x, y, 'h400);
        repeat (3) @(posedge cclk);
        #1;
    endtask

    // Frame strobe captured at the next edge; v0 is touch_valid after it, v1 one cycle later.
    task automatic frame(output logic v0, output logic v1);
        bus.new_frame = 1'b1;
        @(posedge cclk);
        #1;
        bus.new_frame = 1'b0;
        v0 = bus.touch_valid;
        @(posedge cclk);
        #1;
        v1 = bus.touch_valid;
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        repeat (2) @(posedge cclk);
        #1;
        checks++; if (bus.touch_x !== 9'd0) begin errors++; $display("FAIL reset_x got=%0d exp=0", bus.touch_x); end
        checks++; if (bus.touch_y !== 9'd0) begin errors++; $display("FAIL reset_y got=%0d exp=0", bus.touch_y); end
        checks++; if (bus.touch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.touch_valid); end
        checks++; if (bus.touch_active !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", bus.touch_active); end
        rstb = 1'b1;
    endtask

    task automatic test_basic();
        logic v0, v1;
        send_set(1000, 800);
        checks++; if (bus.touch_valid !== 1'b0) begin errors++; $display("FAIL basic_prelatch_valid got=%b exp=0", bus.touch_valid); end
        frame(v0, v1);
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", v0); end
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL basic_valid_width got=%b exp=0", v1); end
        checks++; if (bus.touch_x !== 9'd212) begin errors++; $display("FAIL basic_x got=%0d exp=212", bus.touch_x); end
        checks++; if (bus.touch_y !== 9'd125) begin errors++; $display("FAIL basic_y got=%0d exp=125", bus.touch_y); end
        checks++; if (bus.touch_active !== 1'b1) begin errors++; $display("FAIL basic_active got=%b exp=1", bus.touch_active); end
    endtask

    task automatic test_clamp();
        logic v0, v1;
        send_set(4095, 4095);
        frame(v0, v1);
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL clamp_valid got=%b exp=1", v0); end
        checks++; if (bus.touch_x !== 9'd479) begin errors++; $display("FAIL clamp_x got=%0d exp=479", bus.touch_x); end
        checks++; if (bus.touch_y !== 9'd271) begin errors++; $display("FAIL clamp_y got=%0d exp=271", bus.touch_y); end
        send_set(100, 200);
        frame(v0, v1);
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL floor_valid got=%b exp=1", v0); end
        checks++; if (bus.touch_x !== 9'd0) begin errors++; $display("FAIL floor_x got=%0d exp=0", bus.touch_x); end
        checks++; if (bus.touch_y !== 9'd0) begin errors++; $display("FAIL floor_y got=%0d exp=0", bus.touch_y); end
    endtask

    // Partial set broken by one sample just below threshold; threshold value itself counts as pressed.
    task automatic test_discard();
        logic v0, v1;
        for (int unsigned i = 0; i < 3; i++) send_sample(2000, 2000, 'h100);
        send_sample(2000, 2000, 'h0FF);
        repeat (3) @(posedge cclk);
        #1;
        frame(v0, v1);
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL discard_no_valid got=%b exp=0", v0); end
        checks++; if (bus.touch_active !== 1'b1) begin errors++; $display("FAIL discard_active got=%b exp=1", bus.touch_active); end
        for (int unsigned i = 0; i < 4; i++) send_sample(600, 700, 'h100);
        repeat (3) @(posedge cclk);
        #1;
        frame(v0, v1);
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL discard_valid got=%b exp=1", v0); end
        checks++; if (bus.touch_x !== 9'd112) begin errors++; $display("FAIL discard_x got=%0d exp=112", bus.touch_x); end
        checks++; if (bus.touch_y !== 9'd100) begin errors++; $display("FAIL discard_y got=%0d exp=100", bus.touch_y); end
    endtask

    task automatic test_release();
        logic v0, v1;
        for (int unsigned i = 0; i < 3; i++) begin
            send_sample(900, 900, 0);
            checks++; if (bus.touch_active !== 1'b1) begin errors++; $display("FAIL release_early%0d got=%b exp=1", i, bus.touch_active); end
        end
        send_sample(900, 900, 0);
        checks++; if (bus.touch_active !== 1'b0) begin errors++; $display("FAIL release_active got=%b exp=0", bus.touch_active); end
        checks++; if (bus.touch_x !== 9'd112) begin errors++; $display("FAIL release_hold_x got=%0d exp=112", bus.touch_x); end
        checks++; if (bus.touch_y !== 9'd100) begin errors++; $display("FAIL release_hold_y got=%0d exp=100", bus.touch_y); end
        frame(v0, v1);
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL release_frame_valid got=%b exp=0", v0); end
    endtask

    // Pending result dropped by a release whose final sample edge coincides with new_frame.
    task automatic test_release_wins();
        send_set(1000, 800);
        for (int unsigned i = 0; i < 3; i++) send_sample(0, 0, 0);
        repeat (2) @(posedge cclk);
        #1;
        bus.sample_valid = 1'b1;
        bus.raw_z = '0;
        bus.new_frame = 1'b1;
        @(posedge cclk);
        #1;
        bus.sample_valid = 1'b0;
        bus.new_frame = 1'b0;
        checks++; if (bus.touch_valid !== 1'b0) begin errors++; $display("FAIL relwin_valid got=%b exp=0", bus.touch_valid); end
        checks++; if (bus.touch_active !== 1'b0) begin errors++; $display("FAIL relwin_active got=%b exp=0", bus.touch_active); end
        checks++; if (bus.touch_x !== 9'd112) begin errors++; $display("FAIL relwin_x got=%0d exp=112", bus.touch_x); end
    endtask

    task automatic test_newest_wins();
        logic v0, v1;
        send_set(1000, 800);
        send_set(2000, 800);
        frame(v0, v1);
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL newest_valid got=%b exp=1", v0); end
        checks++; if (bus.touch_x !== 9'd462) begin errors++; $display("FAIL newest_x got=%0d exp=462", bus.touch_x); end
        checks++; if (bus.touch_y !== 9'd125) begin errors++; $display("FAIL newest_y got=%0d exp=125", bus.touch_y); end
        checks++; if (bus.touch_active !== 1'b1) begin errors++; $display("FAIL newest_active got=%b exp=1", bus.touch_active); end
        frame(v0, v1);
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL newest_single_pulse got=%b exp=0", v0); end
    endtask

    // Frame strobe lands on the edge that sets pending, so the latch waits one frame.
    task automatic test_same_edge();
        logic v0, v1;
        for (int unsigned i = 0; i < 4; i++) send_sample(1200, 1000, 'h400);
        frame(v0, v1);
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL sameedge_deferred got=%b exp=0", v0); end
        checks++; if (bus.touch_x !== 9'd462) begin errors++; $display("FAIL sameedge_hold_x got=%0d exp=462", bus.touch_x); end
        frame(v0, v1);
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL sameedge_next_valid got=%b exp=1", v0); end
        checks++; if (bus.touch_x !== 9'd262) begin errors++; $display("FAIL sameedge_x got=%0d exp=262", bus.touch_x); end
        checks++; if (bus.touch_y !== 9'd175) begin errors++; $display("FAIL sameedge_y got=%0d exp=175", bus.touch_y); end
    endtask

    task automatic test_reset_mid();
        logic v0, v1;
        send_sample(4000, 4000, 'h400);
        send_sample(4000, 4000, 'h400);
        test_reset();
        send_set(1000, 800);
        checks++; if (bus.touch_active !== 1'b0) begin errors++; $display("FAIL rstmid_active_pre got=%b exp=0", bus.touch_active); end
        frame(v0, v1);
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL rstmid_valid got=%b exp=1", v0); end
        checks++; if (bus.touch_x !== 9'd212) begin errors++; $display("FAIL rstmid_x got=%0d exp=212", bus.touch_x); end
        checks++; if (bus.touch_y !== 9'd125) begin errors++; $display("FAIL rstmid_y got=%0d exp=125", bus.touch_y); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rstb = 1'b0;
        bus.sample_valid = 1'b0;
        bus.raw_x = '0;
        bus.raw_y = '0;
        bus.raw_z = '0;
        bus.new_frame = 1'b0;
        test_reset();
        test_basic();
        test_clamp();
        test_discard();
        test_release();
        test_release_wins();
        test_newest_wins();
        test_same_edge();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/touch_filter.md
Name: touch_filter

Overview:
- Sits between touchpad_controller and the TFT position latch.
- Qualifies raw x/y/z samples against a pressure threshold and averages 2^AVG_LOG2 qualified samples.
- Converts the average to TFT pixel coordinates (offset, shift, clamp) and publishes the result only on TFT frame boundaries.
- Detects finger release by debouncing low-pressure samples.

Parameters:
AVG_LOG2, 2, log2 of samples averaged per result (1..4)
Z_THRESH, 256, minimum raw_z for a sample to count as "pressed"
X_OFFSET, 150, raw-x offset subtracted before scaling
Y_OFFSET, 300, raw-y offset subtracted before scaling
SCALE_SHIFT, 2, right shift applied after offset subtraction
X_MAX, 479, pixel x clamp
Y_MAX, 271, pixel y clamp
RELEASE_CNT, 4, consecutive low-pressure samples that declare release

Ports:
cclk  in  1  system clock, 100 MHz; the only clock
rstb  in  1  reset, synchronous, active-low
sample_valid  in  1  one-cycle strobe; raw_x/raw_y/raw_z valid this cycle
raw_x  in  12  raw touchpad x
raw_y  in  12  raw touchpad y
raw_z  in  12  raw touchpad pressure
new_frame  in  1  one-cycle strobe from the TFT driver at frame start
touch_x  out  9  latched pixel x
touch_y  out  9  latched pixel y
touch_valid  out  1  one-cycle pulse when touch_x/touch_y update
touch_active  out  1  finger is considered down

Behaviour:
- Reset (rstb=0 at a cclk edge):
  - touch_x=0, touch_y=0, touch_valid=0, touch_active=0.
  - Accumulators, sample count, release count and pending flag cleared; FSM returns to IDLE.
  - Reset mid-accumulation discards the partial set.
- FSM states:
  - IDLE: no qualified samples held.
  - ACCUM: 1..2^AVG_LOG2-1 qualified samples held.
  - CALC: one cycle, calibration registered.
- Sample qualification: a sample is pressed when sample_valid=1 and raw_z>=Z_THRESH. Otherwise, with sample_valid=1, it is low.
- IDLE/ACCUM, on a pressed sample:
  - sum_x+=raw_x, sum_y+=raw_y (width 12+AVG_LOG2, no overflow possible); count++.
  - release count cleared.
  - When count reaches 2^AVG_LOG2 → CALC.
- IDLE/ACCUM, on a low sample:
  - Accumulators and count cleared (partial set discarded); state → IDLE.
  - Release count incremented, saturating at RELEASE_CNT.
- sample_valid is ignored while in CALC; the source's sample period is far longer than 1 cycle.
- CALC, per axis (sub-module touch_calib):
  - avg = sum>>AVG_LOG2.
  - d = avg<OFFSET ? 0 : avg-OFFSET.
  - p = d>>SCALE_SHIFT.
  - out = p>MAX ? MAX : p.
  - Result written to pending_x/pending_y; pending=1; accumulators cleared; → IDLE.
  - Latency: the final sample edge k gives pending visible after edge k+1.
- Newer result while pending=1: overwrites pending_x/pending_y (newest wins).
- Frame latch:
  - At an edge with new_frame=1 and pending=1: touch_x/touch_y←pending; touch_valid=1 for exactly that cycle; touch_active=1; pending←0.
  - new_frame with pending=0: no output change, touch_valid=0.
  - pending set at the same edge as new_frame is not visible; it waits for the next frame.
- Release:
  - When release count reaches RELEASE_CNT: touch_active←0 at that edge; pending←0.
  - touch_x/touch_y hold their last values.
  - Release takes effect immediately, not frame-aligned.
  - If release and a frame latch would occur on the same edge, release wins: no latch, touch_valid=0.
- touch_valid never asserts while touch_active would be 0 after the same edge.

Decomposition:
- Package touch_pkg holds:
  - default parameter constants: Z_THRESH, offsets, SCALE_SHIFT, AVG_LOG2, RELEASE_CNT;
  - TFT dimensions: 480x272, MAX = dim-1;
  - FSM state encoding: IDLE, ACCUM, CALC.
- Sub-module touch_calib (params OFFSET, SHIFT, MAX, IN_W): combinational offset/shift/clamp, instantiated for x and y; its output is registered in touch_filter.

Test Plan:
- 4 pressed samples x=1000,y=800,z=0x400, then new_frame → touch_x=212, touch_y=125, touch_valid 1-cycle pulse, touch_active=1.
- 4 pressed samples x=4095,y=4095 → touch_x=479, touch_y=271 (clamp); x=100,y=200 → 0,0 (offset floor).
- 3 pressed samples, 1 sample z=0x0FF, 4 pressed (x=600,y=700) → only the second set published: touch_x=112, touch_y=100; no intermediate touch_valid.
- Active touch, then 4 samples z=0 → touch_active falls on the 4th sample edge; touch_x/touch_y unchanged; no touch_valid on following new_frames.
- Two complete sets (x=1000 then x=2000) before one new_frame → touch_x=462 (newest wins), single touch_valid pulse; new_frame on the same edge as pending set → latch deferred to next new_frame.
- rstb=0 after 2 pressed samples, release, then 4 pressed samples → result reflects only post-reset samples; all outputs 0 during reset.
